// File: rtl/if_prefetch_pkg.sv
// ============================================================================
// Module  : if_prefetch_pkg
// Brief   : Shared constants for the instruction-fetch front end.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package if_prefetch_pkg;

    localparam logic [31:0] IF_RESET_VECTOR = 32'h0000_3000;
    localparam int unsigned IF_INSTR_BYTES  = 4;

endpackage : if_prefetch_pkg

`default_nettype wire

// File: rtl/if_fifo.sv
// ============================================================================
// Module  : if_fifo
// Brief   : DEPTH x WIDTH synchronous FIFO with flush, count and head taken
//           straight from storage registers.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module if_fifo #(
    parameter  int DEPTH = 4,
    parameter  int WIDTH = 64,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    input  logic             i_flush,
    output logic [CW-1:0]    o_count,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_head
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_push;
    logic             w_pop;

    assign w_push = i_push & (r_count != CW'(DEPTH));
    assign w_pop  = i_pop & (r_count != '0);

    // Storage is reset so the head reads zero straight out of reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    assign o_count = r_count;
    assign o_valid = (r_count != '0);
    assign o_head  = r_mem[r_rd_ptr];

endmodule : if_fifo

`default_nettype wire

// File: rtl/if_prefetch.sv
// ============================================================================
// Module  : if_prefetch
// Brief   : PC generator plus DEPTH-entry prefetch queue in front of a
//           1-cycle-latency instruction memory. Optional macro
//           IF_PERF_CNT_EN adds fetch/redirect performance counters.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module if_prefetch
    import if_prefetch_pkg::*;
#(
    parameter int          XLEN     = 32,
    parameter logic [31:0] RESET_PC = IF_RESET_VECTOR,
    parameter int          DEPTH    = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_instr
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0]     perf_fetch_cnt,
    output logic [31:0]     perf_redirect_cnt
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [XLEN-1:0]   r_fetch_pc;
    logic              r_inflight;
    logic [XLEN-1:0]   r_inflight_pc;
    logic [CW-1:0]     w_count;
    logic [CW:0]       w_occupancy;
    logic              w_room;
    logic              w_pop;
    logic              w_push;
    logic              w_valid;
    logic [2*XLEN-1:0] w_head;

    assign w_pop = w_valid & out_ready;

    // Occupancy after this cycle's pop; a pop implies count >= 1, so no underflow.
    assign w_occupancy = {1'b0, w_count} + (CW+1)'(r_inflight) - (CW+1)'(w_pop);
    assign w_room      = (w_occupancy < (CW+1)'(DEPTH));

    assign imem_req  = rst & ~redirect & w_room;
    assign imem_addr = r_fetch_pc;
    assign w_push    = r_inflight & ~redirect;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_fetch_pc    <= XLEN'(RESET_PC);
            r_inflight    <= 1'b0;
            r_inflight_pc <= '0;
        end else if (redirect) begin
            r_fetch_pc <= redirect_pc & ~XLEN'(3);
            r_inflight <= 1'b0;
        end else if (imem_req) begin
            r_fetch_pc    <= r_fetch_pc + XLEN'(IF_INSTR_BYTES);
            r_inflight_pc <= r_fetch_pc;
            r_inflight    <= 1'b1;
        end else begin
            r_inflight <= 1'b0;
        end
    end

    if_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (2 * XLEN)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_data  ({r_inflight_pc, imem_rdata}),
        .i_pop   (w_pop),
        .i_flush (redirect),
        .o_count (w_count),
        .o_valid (w_valid),
        .o_head  (w_head)
    );

    assign out_valid = w_valid;
    assign out_pc    = w_head[2*XLEN-1:XLEN];
    assign out_instr = w_head[XLEN-1:0];

`ifdef IF_PERF_CNT_EN
    logic [31:0] r_perf_fetch;
    logic [31:0] r_perf_redirect;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_perf_fetch    <= '0;
            r_perf_redirect <= '0;
        end else begin
            if (w_pop) begin
                r_perf_fetch <= r_perf_fetch + 32'd1;
            end
            if (redirect) begin
                r_perf_redirect <= r_perf_redirect + 32'd1;
            end
        end
    end

    assign perf_fetch_cnt    = r_perf_fetch;
    assign perf_redirect_cnt = r_perf_redirect;
`endif

endmodule : if_prefetch

`default_nettype wire

// File: doc/if_prefetch.md
# if_prefetch

Parametrised instruction-fetch front end: it replaces the single-register PC stage with a PC generator plus a DEPTH-entry prefetch queue. It drives a synchronous instruction memory with a fixed 1-cycle read latency and hands {pc, instr} pairs to decode over a valid/ready handshake. A branch/jump redirect from EX flushes the queue and all in-flight fetches. It sits between the instruction memory and the IF/ID boundary.

## Interface
- XLEN, 32, address and instruction width
- RESET_PC, 32'h3000, first fetch address after reset; bits [1:0] must be 0
- DEPTH, 4, prefetch queue entries; power of two, ≥2
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous assert, active-low (0 = reset)
- redirect  in  1  branch/jump taken; highest priority
- redirect_pc  in  XLEN  new fetch address; bits [1:0] ignored, forced to 0
- imem_req  out  1  fetch issued this cycle
- imem_addr  out  XLEN  fetch address, valid when imem_req=1
- imem_rdata  in  XLEN  instruction for the request issued in the previous cycle
- out_valid  out  1  queue head valid
- out_ready  in  1  decode accepts head (deasserted = stall)
- out_pc  out  XLEN  head PC
- out_instr  out  XLEN  head instruction

## Operation
- State: fetch_pc (XLEN), inflight (1 bit), inflight_pc (XLEN), queue of DEPTH entries {pc, instr}, count (log2(DEPTH)+1 bits).
- pop = out_valid & out_ready.
- room = (count + inflight − pop) < DEPTH.
- imem_req = rst & ~redirect & room. imem_addr = fetch_pc.
- On issue: fetch_pc <= fetch_pc + 4 (modulo 2^XLEN; wraps from all-ones−3 to 0). inflight <= 1. inflight_pc <= fetch_pc.
- Response: when inflight=1 and redirect=0, {inflight_pc, imem_rdata} is pushed at the cycle's edge. inflight clears unless a new issue occurs in the same cycle.
- Redirect in cycle t:
  - imem_req=0 in cycle t.
  - Queue is emptied (count <= 0).
  - Any response arriving in t is dropped, and inflight <= 0.
  - fetch_pc <= {redirect_pc[XLEN-1:2], 2'b00}.
  - pop in the same cycle is still treated as accepted by decode, but it has no effect on the cleared queue.
- Push and pop in the same cycle: count unchanged.
- A push never occurs with count=DEPTH; room guarantees this.
- out_valid = (count != 0). out_pc/out_instr come from queue head storage, so they are registered.

## Timing
- Reset values: fetch_pc=RESET_PC, inflight=0, count=0, out_valid=0, out_pc=0, out_instr=0. imem_req is 0 while rst=0.
- Reset asserted mid-operation clears all state immediately, regardless of pending fetches.
- First cycle after reset release (c0): imem_req=1, imem_addr=RESET_PC. Data is pushed at the end of c1. out_valid=1 in c2.
- Redirect at cycle t: fetch at redirect_pc in t+1, push at end of t+2, out_valid in t+3. The redirect penalty is 3 cycles.
- Steady state with out_ready held 1: one instruction per cycle, no bubbles.
- out_ready=0: issue stops once count+inflight reaches DEPTH. out_valid stays 1 and head entries are held stable.

## Configuration
- IF_PERF_CNT_EN defined: adds outputs perf_fetch_cnt and perf_redirect_cnt, both 32 bits, both reset to 0.
  - perf_fetch_cnt increments on every pop.
  - perf_redirect_cnt increments on every redirect cycle.
  - Both wrap at 2^32.
- IF_PERF_CNT_EN undefined: these ports and counters do not exist.

## Structure
- Shared MACRO header holds the default reset vector (3000h) and the instruction byte size (4).
- Natural sub-module: if_fifo, a synchronous DEPTH×(2·XLEN) FIFO with push, pop, synchronous flush, count, and registered head outputs.
- PC/inflight logic and the room calculation stay in if_prefetch.

## Test plan
- Reset release, out_ready=1, memory returns addr^32'hFFFF_FFFF → out_pc sequence 3000h, 3004h, 3008h… from c2, one per cycle, correct instr each.
- out_ready=0 from c2 for 10 cycles, DEPTH=4 → imem_req drops after 4 entries are resident/in flight; queue holds 3000h–300Ch; release → those pop in order, no loss or duplicate.
- redirect=1, redirect_pc=4003h at an arbitrary cycle with full queue → out_valid=0 next cycle; first popped pc=4000h exactly 3 cycles after redirect; no stale pre-redirect PC ever appears.
- Back-to-back redirects (5000h then 6000h in consecutive cycles) → only 6000h stream emerges.
- fetch_pc start near wrap (RESET_PC=32'hFFFF_FFF8) → pcs FFFF_FFF8h, FFFF_FFFCh, 0000_0000h.
- rst asserted while inflight=1 and count=2 → outputs return to reset values immediately; after release, fetch restarts at RESET_PC. With IF_PERF_CNT_EN defined, both counters read 0.
